// File: rtl/ccc_cfg_seq_if.sv
// Request/divider inputs, PLL lock and serial configuration outputs of ccc_cfg_seq.
interface ccc_cfg_seq_if;
  logic       REQ;
  logic [4:0] OADIV;
  logic [4:0] OBDIV;
  logic [4:0] OCDIV;
  logic       LOCK;
  logic       SDIN;
  logic       SCLK;
  logic       SSHIFT;
  logic       SUPDATE;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  modport master (
    output REQ, OADIV, OBDIV, OCDIV, LOCK,
    input  SDIN, SCLK, SSHIFT, SUPDATE, BUSY, DONE, ERR
  );

  modport slave (
    input  REQ, OADIV, OBDIV, OCDIV, LOCK,
    output SDIN, SCLK, SSHIFT, SUPDATE, BUSY, DONE, ERR
  );
endinterface

// File: rtl/ccc_cfg_seq.sv
// CCC dynamic-configuration sequencer: shifts a 15-bit divider word into the
// CCC LSB first, strobes the update, then waits for a stable PLL lock.
module ccc_cfg_seq #(
  parameter int SCLK_HALF    = 2,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int LOCK_STABLE  = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  ccc_cfg_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    UPDATE,
    WAIT_LOCK,
    FINISH
  } state_t;

  localparam logic [7:0]  HALF_LAST    = 8'(SCLK_HALF - 1);
  localparam logic [7:0]  STABLE_TERM  = 8'(LOCK_STABLE);
  localparam logic [15:0] TIMEOUT_TERM = 16'(LOCK_TIMEOUT);
  localparam logic [3:0]  LAST_BIT     = 4'd14;

  state_t      state_q, state_d;
  logic [14:0] word_q, word_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  ph_cnt_q, ph_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        lock_meta_q, lock_meta_d;
  logic        lock_s_q, lock_s_d;
  logic        sdin_q, sdin_d;
  logic        sclk_q, sclk_d;
  logic        sshift_q, sshift_d;
  logic        supdate_q, supdate_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Counters stop at their terminal value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] term);
    return (v >= term) ? term : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic [15:0] term);
    return (v >= term) ? term : v + 16'd1;
  endfunction

  // Next-state, datapath updates and registered-output values.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bit_cnt_d   = bit_cnt_q;
    ph_cnt_d    = ph_cnt_q;
    phase_d     = phase_q;
    stab_cnt_d  = stab_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    lock_meta_d = bus.LOCK;
    lock_s_d    = lock_meta_q;

    case (state_q)
      IDLE: begin
        if (bus.REQ) state_d = LOAD;
      end
      LOAD: begin
        word_d    = {bus.OCDIV, bus.OBDIV, bus.OADIV};
        bit_cnt_d = 4'd0;
        ph_cnt_d  = 8'd0;
        phase_d   = 1'b0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (ph_cnt_q >= HALF_LAST) begin
          ph_cnt_d = 8'd0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // End of the high phase: the CCC has sampled this bit, move to the next.
            phase_d = 1'b0;
            word_d  = {1'b0, word_q[14:1]};
            if (bit_cnt_q == LAST_BIT) state_d = UPDATE;
            else bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          ph_cnt_d = ph_cnt_q + 8'd1;
        end
      end
      UPDATE: begin
        if (ph_cnt_q >= HALF_LAST) begin
          ph_cnt_d   = 8'd0;
          stab_cnt_d = 8'd0;
          tmo_cnt_d  = 16'd0;
          state_d    = WAIT_LOCK;
        end else begin
          ph_cnt_d = ph_cnt_q + 8'd1;
        end
      end
      WAIT_LOCK: begin
        stab_cnt_d = lock_s_q ? sat_inc8(stab_cnt_q, STABLE_TERM) : 8'd0;
        tmo_cnt_d  = sat_inc16(tmo_cnt_q, TIMEOUT_TERM);
        // Lock confirmation takes priority over a simultaneous timeout.
        if (stab_cnt_d >= STABLE_TERM) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (tmo_cnt_d >= TIMEOUT_TERM) begin
          state_d = FINISH;
          err_d   = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    busy_d    = (state_d != IDLE);
    sshift_d  = (state_d == SHIFT);
    sclk_d    = (state_d == SHIFT) && phase_d;
    sdin_d    = (state_d == SHIFT) && word_d[0];
    supdate_d = (state_d == UPDATE);
  end

  // State, datapath, synchronizer and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      word_q      <= '0;
      bit_cnt_q   <= '0;
      ph_cnt_q    <= '0;
      phase_q     <= 1'b0;
      stab_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      sdin_q      <= 1'b0;
      sclk_q      <= 1'b0;
      sshift_q    <= 1'b0;
      supdate_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_cnt_q   <= bit_cnt_d;
      ph_cnt_q    <= ph_cnt_d;
      phase_q     <= phase_d;
      stab_cnt_q  <= stab_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      sdin_q      <= sdin_d;
      sclk_q      <= sclk_d;
      sshift_q    <= sshift_d;
      supdate_q   <= supdate_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.SDIN    = sdin_q;
  assign bus.SCLK    = sclk_q;
  assign bus.SSHIFT  = sshift_q;
  assign bus.SUPDATE = supdate_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_ccc_cfg_seq.sv
// Scoreboard bench for ccc_cfg_seq: stimulus queues expected serial bits and
// DONE/ERR events; a monitor pops and compares as the DUT produces them.
module tb_ccc_cfg_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ccc_cfg_seq_if bus ();
  ccc_cfg_seq_if bus2 ();

  ccc_cfg_seq dut (.CLK(clk), .RESET(rst), .bus(bus.slave));
  ccc_cfg_seq #(.LOCK_STABLE(4), .LOCK_TIMEOUT(4)) dut2 (.CLK(clk), .RESET(rst), .bus(bus2.slave));

  typedef struct {
    bit is_err;
    int lat;
  } ev_t;

  int   n_chk = 0;
  int   n_pass = 0;
  logic exp_bits[$];
  ev_t  exp_ev[$];
  int   lock_mode = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // LOCK driver: 0 = low, 1 = high, 2 = 10 cycles high / 1 cycle low.
  initial begin
    int tog;
    tog = 0;
    bus.LOCK = 1'b0;
    forever begin
      @(negedge clk);
      case (lock_mode)
        0: bus.LOCK = 1'b0;
        1: bus.LOCK = 1'b1;
        default: begin
          bus.LOCK = (tog != 10);
          tog = (tog == 10) ? 0 : tog + 1;
        end
      endcase
    end
  end

  // Monitor: checks serial bits at SCLK rises, SCLK period, SUPDATE width,
  // DONE/ERR kind and latency from WAIT_LOCK entry, and BUSY after FINISH.
  initial begin
    logic sclk_prev, supd_prev, busy_chk;
    int   wcnt, gap, nrise, upd_len;
    ev_t  ev;
    sclk_prev = 0; supd_prev = 0; busy_chk = 0;
    wcnt = 0; gap = 0; nrise = 0; upd_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sclk_prev = 0; supd_prev = 0; busy_chk = 0;
        wcnt = 0; gap = 0; nrise = 0; upd_len = 0;
      end else begin
        gap++;
        wcnt++;
        if (busy_chk) begin
          chk("busy_after_finish", bus.BUSY, 0);
          busy_chk = 0;
        end
        if (bus.SCLK && !sclk_prev) begin
          chk("sclk_rise_expected", exp_bits.size() > 0, 1);
          if (exp_bits.size() > 0) begin
            chk("sdin_bit", bus.SDIN, exp_bits.pop_front());
            chk("sshift_at_rise", bus.SSHIFT, 1);
            if (nrise > 0) chk("sclk_period", gap, 4);
          end
          nrise++;
          gap = 0;
        end
        if (bus.SUPDATE) upd_len++;
        if (supd_prev && !bus.SUPDATE) begin
          chk("supdate_len", upd_len, 2);
          upd_len = 0;
          wcnt = 0;
        end
        if (bus.DONE || bus.ERR) begin
          chk("done_err_exclusive", bus.DONE & bus.ERR, 0);
          chk("pulse_expected", exp_ev.size() > 0, 1);
          if (exp_ev.size() > 0) begin
            ev = exp_ev.pop_front();
            chk("pulse_is_err", bus.ERR, ev.is_err);
            chk("pulse_latency", wcnt, ev.lat);
            chk("sclk_count", nrise, 15);
          end
          nrise = 0;
          busy_chk = 1;
        end
        sclk_prev = bus.SCLK;
        supd_prev = bus.SUPDATE;
      end
    end
  end

  task automatic push_bits(input logic [14:0] w);
    for (int i = 0; i < 15; i++) exp_bits.push_back(w[i]);
  endtask

  task automatic push_ev(input bit is_err, input int lat);
    ev_t e;
    e.is_err = is_err;
    e.lat = lat;
    exp_ev.push_back(e);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    bus.REQ = 1'b1;
    @(negedge clk);
    bus.REQ = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_ev.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_event_seen"}, exp_ev.size(), 0);
    chk({name, "_bits_drained"}, exp_bits.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_xfer(input string name, input logic [4:0] a, b, c, input logic [14:0] w_exp,
                          input bit is_err, input int lat, input int budget);
    bus.OADIV = a;
    bus.OBDIV = b;
    bus.OCDIV = c;
    push_bits(w_exp);
    push_ev(is_err, lat);
    pulse_req();
    wait_drain(name, budget);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_sdin"}, bus.SDIN, 0);
    chk({name, "_sclk"}, bus.SCLK, 0);
    chk({name, "_sshift"}, bus.SSHIFT, 0);
    chk({name, "_supdate"}, bus.SUPDATE, 0);
    chk({name, "_busy"}, bus.BUSY, 0);
    chk({name, "_done"}, bus.DONE, 0);
    chk({name, "_err"}, bus.ERR, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, n, d2, e2;
    logic prev;
    bus.REQ = 0; bus.OADIV = 0; bus.OBDIV = 0; bus.OCDIV = 0;
    bus2.REQ = 0; bus2.OADIV = 5'h02; bus2.OBDIV = 5'h04; bus2.OCDIV = 5'h06; bus2.LOCK = 1'b1;

    // Reset state
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Spec vector, LOCK high: bits 1,0,0,0,0,1,1,0,0,0,1,1,0,0,0
    lock_mode = 1;
    run_xfer("vec_spec", 5'd1, 5'd3, 5'd3, 15'h0C61, 0, 16, 400);
    // All-ones / zero / alternating fields
    run_xfer("vec_mixed", 5'h1F, 5'h00, 5'h15, 15'h541F, 0, 16, 400);

    // LOCK held low: ERR 1024 cycles after WAIT_LOCK entry
    lock_mode = 0;
    run_xfer("lock_low", 5'h0A, 5'h15, 5'h00, 15'h02AA, 1, 1024, 1500);

    // LOCK 10 high / 1 low: never 16 stable cycles, so timeout
    lock_mode = 2;
    run_xfer("lock_toggle", 5'd1, 5'd3, 5'd3, 15'h0C61, 1, 1024, 1500);

    // Reset after the 7th SCLK rise aborts with no pulse
    lock_mode = 1;
    bus.OADIV = 5'h1F; bus.OBDIV = 5'h00; bus.OCDIV = 5'h15;
    push_bits(15'h541F);
    pulse_req();
    rises = 0; n = 0; prev = 0;
    while (rises < 7 && n < 200) begin
      @(negedge clk);
      if (bus.SCLK && !prev) rises++;
      prev = bus.SCLK;
      n++;
    end
    chk("abort_seven_rises", rises, 7);
    rst = 1'b1;
    #1 chk_all_zero("abort");
    exp_bits.delete();
    @(negedge clk);
    // REQ accepted on the first edge after release
    bus.OADIV = 5'h12; bus.OBDIV = 5'h07; bus.OCDIV = 5'h19;
    push_bits(15'h64F2);
    push_ev(0, 16);
    rst = 1'b0;
    bus.REQ = 1'b1;
    @(posedge clk);
    #1 chk("first_edge_accept_busy", bus.BUSY, 1);
    @(negedge clk);
    bus.REQ = 1'b0;
    wait_drain("after_abort", 400);

    // REQ during SHIFT is ignored: one transfer, one DONE
    bus.OADIV = 5'd1; bus.OBDIV = 5'd3; bus.OCDIV = 5'd3;
    push_bits(15'h0C61);
    push_ev(0, 16);
    pulse_req();
    repeat (20) @(negedge clk);
    chk("in_shift", bus.SSHIFT, 1);
    bus.REQ = 1'b1;
    repeat (2) @(negedge clk);
    bus.REQ = 1'b0;
    wait_drain("req_in_shift", 400);
    repeat (100) @(negedge clk);
    chk("no_second_xfer_busy", bus.BUSY, 0);
    chk("no_second_xfer_bits", exp_bits.size(), 0);

    // LOCK_STABLE = LOCK_TIMEOUT = 4: both reached together, DONE wins
    @(negedge clk);
    bus2.REQ = 1'b1;
    @(negedge clk);
    bus2.REQ = 1'b0;
    d2 = 0; e2 = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus2.DONE) d2++;
      if (bus2.ERR) e2++;
    end
    chk("tie_done_count", d2, 1);
    chk("tie_err_count", e2, 0);
    chk("tie_busy_idle", bus2.BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ccc_cfg_seq.md
CCC_CFG_SEQ -- requirements
Module: ccc_cfg_seq

Interface
REQ-001 Parameter SCLK_HALF, default 2, CLK cycles per SCLK phase (legal range 1..255).
REQ-002 Parameter LOCK_TIMEOUT, default 1024, CLK cycles allowed for lock after update (legal range 1..65535).
REQ-003 Parameter LOCK_STABLE, default 16, consecutive synchronized LOCK-high cycles required to declare lock (legal range 1..255).
REQ-004 CLK  input  1  single clock for all logic.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 REQ  input  1  request to apply a new divider configuration; sampled only in IDLE.
REQ-007 OADIV  input  5  requested GLA output divider code.
REQ-008 OBDIV  input  5  requested GLB output divider code.
REQ-009 OCDIV  input  5  requested GLC output divider code.
REQ-010 LOCK  input  1  CCC PLL lock; asynchronous to CLK.
REQ-011 SDIN  output  1  serial configuration data to CCC.
REQ-012 SCLK  output  1  serial configuration clock to CCC.
REQ-013 SSHIFT  output  1  shift enable to CCC configuration register.
REQ-014 SUPDATE  output  1  update strobe: transfers the shifted word into the active CCC configuration.
REQ-015 BUSY  output  1  high whenever the state is not IDLE.
REQ-016 DONE  output  1  one-cycle pulse: configuration applied and lock confirmed.
REQ-017 ERR  output  1  one-cycle pulse: lock not confirmed within LOCK_TIMEOUT.

Function
REQ-018 LOCK SHALL pass through a 2-flop synchronizer before use; the synchronized value is LOCK_S.
REQ-019 States: IDLE, LOAD, SHIFT, UPDATE, WAIT_LOCK, FINISH.
REQ-020 IDLE -> LOAD when REQ=1; the request SHALL be ignored in any other state (no queuing).
REQ-021 LOAD (1 cycle): capture word W[14:0] = {OCDIV, OBDIV, OADIV}; clear bit counter; -> SHIFT.
REQ-022 SHIFT: SSHIFT=1; SDIN = W[0] (LSB first); each bit = SCLK low for SCLK_HALF cycles, then high for SCLK_HALF cycles; W shifts right by one at the end of the SCLK-high phase.
REQ-023 SDIN SHALL change only while SCLK=0; the CCC samples SDIN on the rising SCLK edge.
REQ-024 After exactly 15 SCLK rising edges, -> UPDATE, with SSHIFT=0 and SCLK=0.
REQ-025 UPDATE: SUPDATE=1 for exactly SCLK_HALF cycles; then clear the lock-stable counter and the timeout counter; -> WAIT_LOCK.
REQ-026 WAIT_LOCK: the stable counter increments while LOCK_S=1 and clears to 0 on any LOCK_S=0; the timeout counter increments every cycle.
REQ-027 When the stable counter reaches LOCK_STABLE, -> FINISH with a pending DONE; if the timeout counter reaches LOCK_TIMEOUT first, -> FINISH with a pending ERR.
REQ-028 If both conditions become true in the same cycle, DONE SHALL win and ERR SHALL NOT pulse.
REQ-029 FINISH (1 cycle): pulse exactly one of DONE or ERR; -> IDLE. A REQ held high re-enters LOAD on the following cycle.
REQ-030 Counters SHALL be sized to the parameter maxima and SHALL NOT wrap; each saturates at its terminal value.
REQ-031 All outputs SHALL be registered.
REQ-032 DONE and ERR SHALL never both be 1 in the same cycle.

Reset
REQ-033 RESET=1 SHALL force the state to IDLE, and SDIN, SCLK, SSHIFT, SUPDATE, BUSY, DONE and ERR to 0.
REQ-034 RESET=1 SHALL clear the word register, all counters and the synchronizer flops.
REQ-035 Reset asserted mid-shift or mid-update SHALL abort the transfer immediately, with no DONE or ERR pulse.
REQ-036 After RESET is released, the block SHALL accept REQ on the first rising CLK edge.

Verification
REQ-037 OADIV=1, OBDIV=3, OCDIV=3, REQ pulse, LOCK high throughout, default parameters -> SDIN bit sequence 1,0,0,0,0, 1,1,0,0,0, 1,1,0,0,0; 15 SCLK pulses of 4-cycle period; one SUPDATE of 2 cycles; DONE exactly 16 cycles after LOCK_S is seen high plus the FINISH cycle.
REQ-038 LOCK held low -> ERR pulses once, 1024 cycles after WAIT_LOCK entry; no DONE; BUSY=0 on the next cycle.
REQ-039 LOCK toggling with a 10-cycle high / 1-cycle low pattern -> the stable counter never reaches 16; ERR pulses at timeout.
REQ-040 RESET asserted after the 7th SCLK edge -> all outputs 0 in the same cycle; a new REQ afterwards produces a complete 15-bit transfer.
REQ-041 REQ asserted during SHIFT -> ignored; exactly one transfer occurs and exactly one DONE pulse is produced.
REQ-042 Parameters LOCK_STABLE=LOCK_TIMEOUT=4 with LOCK high from UPDATE -> DONE pulses and ERR stays 0.
